ddr_link_downstream_rx: RTL and testbench

//  Receive end of the DDR upstream link: accepts the per-channel beat stream (pos/neg halves already

---
 rtl/ddr_link_downstream_rx.sv | 201 ++++++++++++++++++++
 tb/tb_ddr_link_downstream_rx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_link_downstream_rx.sv
// ----------------------------------------------------------------------------
// ddr_link_downstream_rx
//
// Receive end of the DDR link. The PHY capture flops hand over one
// CHANNEL_WIDTH beat per io clock, with the pos and neg halves already merged.
// This block reassembles BEATS beats into one core word and holds the words in
// a small FIFO. It returns credit to the transmitter as a toggling token, once
// every TOKEN_DECIMATION words that the core consumes.
//
// Parameters
//   CHANNEL_WIDTH     bits per received beat
//   BEATS             beats per core word (core word = CHANNEL_WIDTH*BEATS)
//   FIFO_DEPTH_LG     log2 of the FIFO depth in words (must be >= 1)
//   TOKEN_DECIMATION  dequeues per token toggle; power of 2, divides the depth
//
// Ports
//   clk           in   clock
//   rst           in   synchronous, active-high reset
//   io_valid_i    in   beat valid
//   io_data_i     in   beat data (beat 0 lands in the word LSBs)
//   core_valid_o  out  FIFO head word valid
//   core_data_o   out  FIFO head word (0 while the FIFO is empty)
//   core_yumi_i   in   core consumes the head this cycle
//   io_token_o    out  credit token, toggles once per TOKEN_DECIMATION pops
//   overflow_o    out  sticky: a completed word arrived while the FIFO was full
//
// Optional build macro DDR_RX_BEAT_PARITY_EN adds these ports:
//   io_parity_i   in   even parity bit over io_data_i, checked on each valid beat
//   parity_err_o  out  sticky: a word was dropped because a beat had bad parity
// A word with any bad beat is dropped when it completes. It is not written to
// the FIFO, so it never returns credit.
// ----------------------------------------------------------------------------
module ddr_link_downstream_rx #(
  parameter int CHANNEL_WIDTH    = 16,
  parameter int BEATS            = 4,
  parameter int FIFO_DEPTH_LG    = 3,
  parameter int TOKEN_DECIMATION = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              io_valid_i,
  input  logic [CHANNEL_WIDTH-1:0]          io_data_i,
  output logic                              core_valid_o,
  output logic [CHANNEL_WIDTH*BEATS-1:0]    core_data_o,
  input  logic                              core_yumi_i,
  output logic                              io_token_o,
  output logic                              overflow_o
`ifdef DDR_RX_BEAT_PARITY_EN
  ,
  input  logic                              io_parity_i,
  output logic                              parity_err_o
`endif
);

  localparam int WORD_WIDTH = CHANNEL_WIDTH * BEATS;
  localparam int DEPTH      = 1 << FIFO_DEPTH_LG;
  localparam int BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DEQ_CNT_W  = (TOKEN_DECIMATION > 1) ? $clog2(TOKEN_DECIMATION) : 1;
  localparam int PTR_W      = FIFO_DEPTH_LG + 1;

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);
  localparam logic [DEQ_CNT_W-1:0]  LAST_DEQ  = DEQ_CNT_W'(TOKEN_DECIMATION - 1);

  // --------------------------------------------------------------------------
  // Beat assembly
  // --------------------------------------------------------------------------
  logic [BEAT_CNT_W-1:0] beat_cnt;
  logic [WORD_WIDTH-1:0] assembly;
  logic [WORD_WIDTH-1:0] full_word;
  logic                  word_done;
  logic                  word_bad;

  assign word_done = io_valid_i && (beat_cnt == LAST_BEAT);

  // The final beat does not pass through the assembly register. It is merged
  // in here so that the FIFO write happens on the same edge that captures it.
  // NOTE: every signal written in always_comb gets a default value first. A
  // path that leaves a signal unassigned would infer a latch.
  always_comb begin
    full_word = assembly;
    full_word[(BEATS-1)*CHANNEL_WIDTH +: CHANNEL_WIDTH] = io_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples its pre-edge value and the order of the statements does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      assembly <= '0;
    end else if (io_valid_i) begin
      for (int k = 0; k < BEATS - 1; k++) begin
        if (beat_cnt == BEAT_CNT_W'(k)) begin
          assembly[k*CHANNEL_WIDTH +: CHANNEL_WIDTH] <= io_data_i;
        end
      end
      beat_cnt <= word_done ? '0 : beat_cnt + BEAT_CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Optional per-beat parity check
  // --------------------------------------------------------------------------
`ifdef DDR_RX_BEAT_PARITY_EN
  logic beat_bad;
  logic word_bad_q;

  // Even parity: the data bits and the parity bit together hold an even number of ones.
  assign beat_bad = io_valid_i && ((^io_data_i) != io_parity_i);
  assign word_bad = word_bad_q || beat_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_bad_q   <= 1'b0;
      parity_err_o <= 1'b0;
    end else if (io_valid_i) begin
      // The bad mark covers one word only. Clear it when that word completes.
      word_bad_q <= word_done ? 1'b0 : word_bad;
      if (word_done && word_bad) begin
        parity_err_o <= 1'b1;
      end
    end
  end
`else
  assign word_bad = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Word FIFO
  // --------------------------------------------------------------------------
  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  wr_en;
  logic                  pop;

  // The pointers carry one extra wrap bit. Full means the indexes are equal and
  // the wrap bits differ. Empty means the pointers are fully equal.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr == {~rd_ptr[PTR_W-1], rd_ptr[PTR_W-2:0]});

  // Full is the registered state from the start of the cycle. A pop in the
  // same cycle does not free a slot for the incoming word.
  assign wr_en = word_done && !word_bad && !full;
  assign pop   = core_yumi_i && !empty;

  // NOTE: the storage array has no reset. Its contents are never visible until
  // they are written, because the read port is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[FIFO_DEPTH_LG-1:0]] <= full_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (word_done && !word_bad && full) begin
        overflow_o <= 1'b1;
      end
    end
  end

  assign core_valid_o = !empty;
  assign core_data_o  = empty ? '0 : mem[rd_ptr[FIFO_DEPTH_LG-1:0]];

  // --------------------------------------------------------------------------
  // Credit token
  // --------------------------------------------------------------------------
  logic [DEQ_CNT_W-1:0] deq_cnt;
  logic                 token_pending;

  // The pop that wraps the counter only arms token_pending. The token itself
  // toggles on the following edge, so credit returns one cycle after the pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      deq_cnt       <= '0;
      token_pending <= 1'b0;
      io_token_o    <= 1'b0;
    end else begin
      token_pending <= pop && (deq_cnt == LAST_DEQ);
      if (pop) begin
        deq_cnt <= (deq_cnt == LAST_DEQ) ? '0 : deq_cnt + DEQ_CNT_W'(1);
      end
      if (token_pending) begin
        io_token_o <= ~io_token_o;
      end
    end
  end

endmodule

// File: tb/tb_ddr_link_downstream_rx.sv
// ----------------------------------------------------------------------------
// tb_ddr_link_downstream_rx
//
// Self-checking bench for ddr_link_downstream_rx in its default configuration.
// Building with DDR_RX_BEAT_PARITY_EN defined adds the parity scenario.
//
// Every word the bench expects the FIFO to accept is pushed to a scoreboard
// queue when it is driven. The entry is popped and compared when the core
// consumes that word. Inputs change 1 ns after the rising edge, and outputs
// are sampled at that same point.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ddr_link_downstream_rx;

  localparam int CW    = 16;
  localparam int BEATS = 4;
  localparam int DEPTH = 8;
  localparam int WW    = CW * BEATS;

  logic          clk = 1'b0;
  logic          rst;
  logic          io_valid_i;
  logic [CW-1:0] io_data_i;
  logic          core_valid_o;
  logic [WW-1:0] core_data_o;
  logic          core_yumi_i;
  logic          io_token_o;
  logic          overflow_o;
`ifdef DDR_RX_BEAT_PARITY_EN
  logic          io_parity_i;
  logic          parity_err_o;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  logic [WW-1:0] sb[$];

  always #5 clk = ~clk;

  ddr_link_downstream_rx dut (
    .clk          (clk),
    .rst          (rst),
    .io_valid_i   (io_valid_i),
    .io_data_i    (io_data_i),
    .core_valid_o (core_valid_o),
    .core_data_o  (core_data_o),
    .core_yumi_i  (core_yumi_i),
    .io_token_o   (io_token_o),
    .overflow_o   (overflow_o)
`ifdef DDR_RX_BEAT_PARITY_EN
    ,
    .io_parity_i  (io_parity_i),
    .parity_err_o (parity_err_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    io_valid_i  = 1'b0;
    core_yumi_i = 1'b0;
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic beat(input logic [CW-1:0] d);
    io_valid_i = 1'b1;
    io_data_i  = d;
`ifdef DDR_RX_BEAT_PARITY_EN
    io_parity_i = ^d;
`endif
    tick();
    io_valid_i = 1'b0;
  endtask

  // Drive a whole word, optionally with idle cycles between beats. The word is
  // queued only if the bench model says the FIFO has room for it.
  task automatic send_word(input logic [WW-1:0] w, input int gap);
    for (int k = 0; k < BEATS; k++) begin
      beat(w[k*CW +: CW]);
      if (k < BEATS - 1) repeat (gap) tick();
    end
    if (sb.size() < DEPTH) sb.push_back(w);
  endtask

  task automatic pop_word(input string tag);
    logic [WW-1:0] exp;
    check({tag, "_valid"}, core_valid_o, 1'b1);
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    check({tag, "_data"}, core_data_o, exp);
    core_yumi_i = 1'b1;
    tick();
    core_yumi_i = 1'b0;
  endtask

  function automatic logic [WW-1:0] pattern(input int i);
    return {16'(16'hD000 + i), 16'(16'hC000 + i), 16'(16'hB000 + i), 16'(16'hA000 + i)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WW-1:0] w;
    rst         = 1'b1;
    io_valid_i  = 1'b0;
    io_data_i   = '0;
    core_yumi_i = 1'b0;
`ifdef DDR_RX_BEAT_PARITY_EN
    io_parity_i = 1'b0;
`endif
    repeat (3) tick();

    // Reset state
    check("rst_valid",    core_valid_o, 1'b0);
    check("rst_data",     core_data_o,  64'h0);
    check("rst_token",    io_token_o,   1'b0);
    check("rst_overflow", overflow_o,   1'b0);
`ifdef DDR_RX_BEAT_PARITY_EN
    check("rst_parity_err", parity_err_o, 1'b0);
`endif
    rst = 1'b0;
    tick();

    // 1: back-to-back beats, visible the cycle after the last beat
    beat(16'h1111); beat(16'h2222); beat(16'h3333);
    check("t1_pre_valid", core_valid_o, 1'b0);
    beat(16'h4444);
    sb.push_back(64'h4444_3333_2222_1111);
    pop_word("t1");
    check("t1_empty", core_valid_o, 1'b0);

    // 2: two idle cycles between beats hold the assembly state
    beat(16'h1111); repeat (2) tick();
    beat(16'h2222); repeat (2) tick();
    beat(16'h3333); repeat (2) tick();
    check("t2_pre_valid", core_valid_o, 1'b0);
    beat(16'h4444);
    sb.push_back(64'h4444_3333_2222_1111);
    pop_word("t2");

    // 3: fill the FIFO, a ninth word is dropped and overflow sticks
    for (int i = 0; i < DEPTH; i++) send_word(pattern(i), 0);
    check("t3_no_overflow", overflow_o, 1'b0);
    send_word(pattern(99), 0);
    check("t3_overflow", overflow_o, 1'b1);
    for (int i = 0; i < DEPTH; i++) pop_word("t3_pop");
    check("t3_drained", core_valid_o, 1'b0);
    check("t3_overflow_sticky", overflow_o, 1'b1);

    // 4: token toggles one cycle after every fourth pop
    do_reset();
    check("t4_overflow_cleared", overflow_o, 1'b0);
    for (int i = 0; i < DEPTH; i++) send_word(pattern(i + 16), 0);
    for (int i = 0; i < 3; i++) pop_word("t4_pop");
    check("t4_tok_after3", io_token_o, 1'b0);
    pop_word("t4_pop");
    check("t4_tok_latency", io_token_o, 1'b0);
    tick();
    check("t4_tok_rise", io_token_o, 1'b1);
    for (int i = 0; i < 4; i++) pop_word("t4_pop");
    check("t4_tok_hold", io_token_o, 1'b1);
    tick();
    check("t4_tok_fall", io_token_o, 1'b0);
    // Yumi while empty must neither pop nor count
    core_yumi_i = 1'b1;
    repeat (6) tick();
    core_yumi_i = 1'b0;
    tick();
    check("t4_empty_yumi_valid", core_valid_o, 1'b0);
    check("t4_empty_yumi_tok",   io_token_o,   1'b0);
    for (int i = 0; i < 4; i++) send_word(pattern(i + 32), 0);
    for (int i = 0; i < 3; i++) pop_word("t4b_pop");
    tick();
    check("t4b_tok_after3", io_token_o, 1'b0);
    pop_word("t4b_pop");
    tick();
    check("t4b_tok_rise", io_token_o, 1'b1);

    // Simultaneous write and pop while not full: occupancy is unchanged
    send_word(pattern(40), 0);
    w = pattern(41);
    for (int k = 0; k < BEATS - 1; k++) beat(w[k*CW +: CW]);
    check("sim_head", core_data_o, sb.pop_front());
    io_valid_i  = 1'b1;
    io_data_i   = w[(BEATS-1)*CW +: CW];
`ifdef DDR_RX_BEAT_PARITY_EN
    io_parity_i = ^io_data_i;
`endif
    core_yumi_i = 1'b1;
    tick();
    io_valid_i  = 1'b0;
    core_yumi_i = 1'b0;
    sb.push_back(w);
    pop_word("sim_new");
    check("sim_single", core_valid_o, 1'b0);

    // A pop in the same cycle as a word completing into a full FIFO frees no slot
    do_reset();
    for (int i = 0; i < DEPTH; i++) send_word(pattern(i + 48), 0);
    w = pattern(77);
    for (int k = 0; k < BEATS - 1; k++) beat(w[k*CW +: CW]);
    check("fullpop_head", core_data_o, sb.pop_front());
    io_valid_i  = 1'b1;
    io_data_i   = w[(BEATS-1)*CW +: CW];
`ifdef DDR_RX_BEAT_PARITY_EN
    io_parity_i = ^io_data_i;
`endif
    core_yumi_i = 1'b1;
    tick();
    io_valid_i  = 1'b0;
    core_yumi_i = 1'b0;
    check("fullpop_overflow", overflow_o, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) pop_word("fullpop_pop");
    check("fullpop_drained", core_valid_o, 1'b0);

    // 5: reset mid-word discards the partial assembly
    do_reset();
    beat(16'h00EE); beat(16'h00FF);
    do_reset();
    check("t5_valid_after_rst", core_valid_o, 1'b0);
    beat(16'h000A); beat(16'h000B); beat(16'h000C); beat(16'h000D);
    sb.push_back(64'h000D_000C_000B_000A);
    pop_word("t5");

`ifdef DDR_RX_BEAT_PARITY_EN
    // 6: bad parity on beat 2 drops the word, the next clean word passes
    w = 64'h4444_3333_2222_1111;
    for (int k = 0; k < BEATS; k++) begin
      io_valid_i  = 1'b1;
      io_data_i   = w[k*CW +: CW];
      io_parity_i = (^io_data_i) ^ (k == 2);
      tick();
    end
    io_valid_i = 1'b0;
    check("t6_no_valid",   core_valid_o, 1'b0);
    check("t6_parity_err", parity_err_o, 1'b1);
    send_word(64'h8888_7777_6666_5555, 0);
    pop_word("t6_clean");
    check("t6_parity_sticky", parity_err_o, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
